// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout engine (20/10/5) with per-denomination stock
//
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   change_valid/_amt/_ready   one change request per transaction, accepted in IDLE only
//   refill                  reload all stocks to STOCK_INIT, honoured in IDLE only
//   deno_20/10/5            one-cycle pulse per coin dispensed
//   done                    one-cycle pulse at end of transaction
//   short_change, remain    unpaid amount report, valid with done, held until next accept
//   stock_20/10/5           current coin stock per denomination
module change_dispenser #(
    parameter int AMT_W      = 8,
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               change_valid,
    input  logic [AMT_W-1:0]   change_amt,
    output logic               change_ready,
    input  logic               refill,
    output logic               deno_20,
    output logic               deno_10,
    output logic               deno_5,
    output logic               done,
    output logic               short_change,
    output logic [AMT_W-1:0]   remain,
    output logic [STOCK_W-1:0] stock_20,
    output logic [STOCK_W-1:0] stock_10,
    output logic [STOCK_W-1:0] stock_5
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PICK,
        S_PULSE,
        S_GAP,
        S_FINISH
    } state_t;

    localparam logic [1:0] C20 = 2'd0;
    localparam logic [1:0] C10 = 2'd1;
    localparam logic [1:0] C5  = 2'd2;

    // Counter must hold GAP_CYC-1 and stay at least one bit wide when GAP_CYC is 0 or 1.
    localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [STOCK_W-1:0] STOCK_RELOAD = STOCK_W'(STOCK_INIT);

    state_t           state, state_nxt;
    logic [AMT_W-1:0] rem;
    logic [1:0]       coin_sel;
    logic [1:0]       coin_nxt;
    logic             have_coin;
    logic [AMT_W-1:0] coin_val;
    logic [GAP_W-1:0] gap_cnt;

    // Greedy choice: largest coin that fits in rem and is still in stock.
    always_comb begin
        have_coin = 1'b1;
        coin_nxt  = C20;
        if (rem >= AMT_W'(20) && stock_20 != '0) begin
            coin_nxt = C20;
        end else if (rem >= AMT_W'(10) && stock_10 != '0) begin
            coin_nxt = C10;
        end else if (rem >= AMT_W'(5) && stock_5 != '0) begin
            coin_nxt = C5;
        end else begin
            have_coin = 1'b0;
        end
    end

    always_comb begin
        case (coin_sel)
            C20:     coin_val = AMT_W'(20);
            C10:     coin_val = AMT_W'(10);
            default: coin_val = AMT_W'(5);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        change_ready = 1'b0;
        deno_20      = 1'b0;
        deno_10      = 1'b0;
        deno_5       = 1'b0;
        done         = 1'b0;
        case (state)
            S_IDLE: begin
                change_ready = 1'b1;
                if (change_valid) begin
                    state_nxt = S_PICK;
                end
            end
            S_PICK: begin
                state_nxt = have_coin ? S_PULSE : S_FINISH;
            end
            S_PULSE: begin
                deno_20   = (coin_sel == C20);
                deno_10   = (coin_sel == C10);
                deno_5    = (coin_sel == C5);
                state_nxt = (GAP_CYC > 0) ? S_GAP : S_PICK;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_PICK;
                end
            end
            S_FINISH: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem          <= '0;
            coin_sel     <= C20;
            gap_cnt      <= '0;
            short_change <= 1'b0;
            remain       <= '0;
            stock_20     <= STOCK_RELOAD;
            stock_10     <= STOCK_RELOAD;
            stock_5      <= STOCK_RELOAD;
        end else begin
            case (state)
                S_IDLE: begin
                    // Refill lands on the same edge as an accept, so the new
                    // transaction already sees the full stocks.
                    if (refill) begin
                        stock_20 <= STOCK_RELOAD;
                        stock_10 <= STOCK_RELOAD;
                        stock_5  <= STOCK_RELOAD;
                    end
                    if (change_valid) begin
                        rem          <= change_amt;
                        short_change <= 1'b0;
                        remain       <= '0;
                    end
                end
                S_PICK: begin
                    if (have_coin) begin
                        coin_sel <= coin_nxt;
                    end else begin
                        // Registered here so the report is already valid in the done cycle.
                        remain       <= rem;
                        short_change <= (rem != '0);
                    end
                end
                S_PULSE: begin
                    rem     <= rem - coin_val;
                    gap_cnt <= GAP_W'(GAP_LOAD);
                    case (coin_sel)
                        C20:     stock_20 <= stock_20 - 1'b1;
                        C10:     stock_10 <= stock_10 - 1'b1;
                        default: stock_5  <= stock_5 - 1'b1;
                    endcase
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed self-checking bench for change_dispenser
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       change_ready;
    logic       refill;
    logic       deno_20, deno_10, deno_5;
    logic       done;
    logic       short_change;
    logic [7:0] remain;
    logic [3:0] stock_20, stock_10, stock_5;

    int n_vec  = 0;
    int n_miss = 0;

    int coin_q[$];
    int cyc_q[$];
    int done_cyc;
    int done_remain;
    int done_short;

    change_dispenser #(
        .AMT_W(8), .STOCK_W(4), .STOCK_INIT(4), .GAP_CYC(2)
    ) dut (
        .clk(clk), .reset(reset),
        .change_valid(change_valid), .change_amt(change_amt), .change_ready(change_ready),
        .refill(refill),
        .deno_20(deno_20), .deno_10(deno_10), .deno_5(deno_5),
        .done(done), .short_change(short_change), .remain(remain),
        .stock_20(stock_20), .stock_10(stock_10), .stock_5(stock_5)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_stocks(input string tag, input int s20, input int s10, input int s5);
        check_val({tag, "_s20"}, 32'(stock_20), s20);
        check_val({tag, "_s10"}, 32'(stock_10), s10);
        check_val({tag, "_s5"},  32'(stock_5),  s5);
    endtask

    // Coins are expected 4 cycles apart (2 + GAP_CYC), first at cycle t0.
    task automatic expect_coins(input string tag, input int n,
                                input int c0, input int c1, input int c2, input int c3,
                                input int t0);
        int ev[4];
        ev = '{c0, c1, c2, c3};
        check_val({tag, "_ncoins"}, coin_q.size(), n);
        for (int i = 0; i < n && i < coin_q.size(); i++) begin
            check_val($sformatf("%s_coin%0d", tag, i), coin_q[i], ev[i]);
            check_val($sformatf("%s_cyc%0d", tag, i), cyc_q[i], t0 + 4 * i);
        end
    endtask

    // Cycle k is counted in negedges after the accept edge.
    task automatic run_txn(input logic [7:0] amt, input int inject_cyc,
                           input int reset_cyc, input bit with_refill);
        int npulse;
        coin_q.delete();
        cyc_q.delete();
        done_cyc    = -1;
        done_remain = -1;
        done_short  = -1;
        @(negedge clk);
        check_val("ready_idle", change_ready, 1);
        change_amt   = amt;
        change_valid = 1'b1;
        refill       = with_refill;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            change_valid = 1'b0;
            refill       = 1'b0;
            npulse = int'(deno_20) + int'(deno_10) + int'(deno_5);
            if (npulse > 0) begin
                check_val("onehot", npulse, 1);
                coin_q.push_back(deno_20 ? 20 : deno_10 ? 10 : 5);
                cyc_q.push_back(k);
            end
            if (done) begin
                done_cyc    = k;
                done_remain = int'(remain);
                done_short  = int'(short_change);
                break;
            end
            if (k == inject_cyc) begin
                check_val("ready_busy", change_ready, 0);
                change_valid = 1'b1;
                change_amt   = 8'd5;
                refill       = 1'b1;
            end
            if (k == reset_cyc) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check_val("rst_pulses", {deno_20, deno_10, deno_5}, 0);
                check_val("rst_done", done, 0);
                check_val("rst_ready", change_ready, 1);
                check_val("rst_remain", remain, 0);
                check_val("rst_short", short_change, 0);
                check_stocks("rst", 4, 4, 4);
                break;
            end
        end
        if (done_cyc < 0 && reset_cyc < 0) begin
            check_val("done_timeout", 0, 1);
        end
    endtask

    initial begin
        reset        = 1'b1;
        change_valid = 1'b0;
        change_amt   = 8'd0;
        refill       = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_val("reset_ready", change_ready, 1);
        check_val("reset_pulses", {deno_20, deno_10, deno_5}, 0);
        check_val("reset_done", done, 0);
        check_val("reset_short", short_change, 0);
        check_val("reset_remain", remain, 0);
        check_stocks("reset", 4, 4, 4);

        // 35 -> 20,10,5
        run_txn(8'd35, -1, -1, 1'b0);
        expect_coins("t1", 3, 20, 10, 5, 0, 2);
        check_val("t1_done_cyc", done_cyc, 14);
        check_val("t1_short", done_short, 0);
        check_val("t1_remain", done_remain, 0);
        check_stocks("t1", 3, 3, 3);

        // zero amount
        run_txn(8'd0, -1, -1, 1'b0);
        check_val("t2_ncoins", coin_q.size(), 0);
        check_val("t2_done_cyc", done_cyc, 2);
        check_val("t2_short", done_short, 0);
        check_val("t2_remain", done_remain, 0);

        // request + refill while busy are ignored
        run_txn(8'd35, 3, -1, 1'b0);
        expect_coins("t5", 3, 20, 10, 5, 0, 2);
        check_val("t5_done_cyc", done_cyc, 14);
        check_val("t5_remain", done_remain, 0);
        check_stocks("t5", 2, 2, 2);
        @(negedge clk);
        check_val("t5_idle_after", change_ready, 1);

        // refill in IDLE
        refill = 1'b1;
        @(negedge clk);
        refill = 1'b0;
        check_stocks("refill", 4, 4, 4);

        // 47 -> 20,20,5 remain 2
        run_txn(8'd47, -1, -1, 1'b0);
        expect_coins("t3", 3, 20, 20, 5, 0, 2);
        check_val("t3_short", done_short, 1);
        check_val("t3_remain", done_remain, 2);
        check_stocks("t3", 2, 4, 3);
        repeat (3) @(negedge clk);
        check_val("t3_remain_held", remain, 2);
        check_val("t3_short_held", short_change, 1);

        // drain stock_20, then 40 must be paid in tens
        run_txn(8'd40, -1, -1, 1'b0);
        expect_coins("t4a", 2, 20, 20, 0, 0, 2);
        check_stocks("t4a", 0, 4, 3);
        run_txn(8'd40, -1, -1, 1'b0);
        expect_coins("t4b", 4, 10, 10, 10, 10, 2);
        check_val("t4b_done_cyc", done_cyc, 18);
        check_val("t4b_remain", done_remain, 0);
        check_stocks("t4b", 0, 0, 3);

        // all stocks exhausted: nothing paid, counters stay at 0
        run_txn(8'd15, -1, -1, 1'b0);
        expect_coins("t7a", 3, 5, 5, 5, 0, 2);
        check_stocks("t7a", 0, 0, 0);
        run_txn(8'd25, -1, -1, 1'b0);
        check_val("t7b_ncoins", coin_q.size(), 0);
        check_val("t7b_done_cyc", done_cyc, 2);
        check_val("t7b_short", done_short, 1);
        check_val("t7b_remain", done_remain, 25);
        check_stocks("t7b", 0, 0, 0);

        // refill together with accept: transaction sees refilled stock
        run_txn(8'd20, -1, -1, 1'b1);
        expect_coins("t8", 1, 20, 0, 0, 0, 2);
        check_val("t8_short", done_short, 0);
        check_stocks("t8", 3, 4, 4);

        // reset during GAP
        run_txn(8'd35, -1, 3, 1'b0);
        check_val("t6_no_done", done_cyc, -1);
        check_val("t6_ncoins", coin_q.size(), 1);
        @(negedge clk);
        check_val("t6_done_after", done, 0);
        check_val("t6_pulses_after", {deno_20, deno_10, deno_5}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
